// File: rtl/op_cycle_counter_pkg.sv
// opcnt_pkg: shared types and helpers for the op_cycle_counter sequencer.
// Holds the FSM state encoding, the terminal-count helper and the
// legal-configuration limits for WIDTH / LEN / READY_DELAY.
package opcnt_pkg;

  // Sequencer states, fixed 2-bit encoding
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2
  } opcnt_state_e;

  // Legal configuration limits
  localparam int unsigned LEN_MIN         = 32'd1;
  localparam int unsigned READY_DELAY_MAX = 32'd1;

  // Terminal count value for an operation of length len (count runs 0..len-1)
  function automatic int unsigned opcnt_term_val(input int unsigned len);
    return len - 32'd1;
  endfunction

  // True when the parameter set lies inside the supported range
  function automatic bit opcnt_cfg_legal(input int unsigned width,
                                         input int unsigned len,
                                         input int unsigned ready_delay);
    return (len >= LEN_MIN) && (len <= (32'd1 << width)) &&
           (ready_delay <= READY_DELAY_MAX);
  endfunction

endpackage

// File: rtl/op_cycle_counter_if.sv
// op_cycle_counter_if: start/abort request and busy/ready/count status bundle.
// The len_in field exists only when OPCNT_RUNTIME_LEN_EN is defined.
interface op_cycle_counter_if #(
  parameter int unsigned WIDTH = 6
);
  logic             start;
  logic             abort;
`ifdef OPCNT_RUNTIME_LEN_EN
  logic [WIDTH-1:0] len_in;
`endif
  logic             busy;
  logic             ready;
  logic [WIDTH-1:0] count;

`ifdef OPCNT_RUNTIME_LEN_EN
  modport master (output start, output abort, output len_in,
                  input  busy,  input  ready, input  count);
  modport slave  (input  start, input  abort, input  len_in,
                  output busy,  output ready, output count);
`else
  modport master (output start, output abort,
                  input  busy,  input  ready, input  count);
  modport slave  (input  start, input  abort,
                  output busy,  output ready, output count);
`endif

endinterface

// File: rtl/op_cycle_counter_term_cmp.sv
// opcnt_term_cmp: raises term_o when the running count sits on the last
// cycle of the operation. With OPCNT_RUNTIME_LEN_EN the terminal value comes
// from the latched length (0 encodes 2^WIDTH, which wraps to all-ones after
// the subtraction); otherwise it is the constant LEN-1.
module opcnt_term_cmp
  import opcnt_pkg::*;
#(
  parameter int unsigned WIDTH = 6,
  parameter int unsigned LEN   = 32
) (
  input  logic [WIDTH-1:0] count_i,
`ifdef OPCNT_RUNTIME_LEN_EN
  input  logic [WIDTH-1:0] len_i,
`endif
  output logic             term_o
);

`ifdef OPCNT_RUNTIME_LEN_EN
  logic [WIDTH-1:0] term_val_s;

  assign term_val_s = len_i - WIDTH'(1);
  assign term_o     = (count_i == term_val_s);
`else
  localparam logic [WIDTH-1:0] TERM_VAL = WIDTH'(opcnt_term_val(LEN));

  assign term_o = (count_i == TERM_VAL);
`endif

endmodule

// File: rtl/op_cycle_counter.sv
// op_cycle_counter: cycle sequencer for multicycle datapaths. A start in IDLE
// launches a run of L cycles; ready pulses once, READY_DELAY cycles after the
// terminal count. abort cancels without a ready pulse. Optional feature
// macro: OPCNT_RUNTIME_LEN_EN (length latched from len_in at start).
module op_cycle_counter
  import opcnt_pkg::*;
#(
  parameter int unsigned WIDTH       = 6,
  parameter int unsigned LEN         = 32,
  parameter int unsigned READY_DELAY = 1
) (
  input  logic               clock,
  input  logic               clr,
  op_cycle_counter_if.slave  bus
);

  opcnt_state_e     state_q;
  logic             busy_q;
  logic             ready_q;
  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;
  logic             term_s;
`ifdef OPCNT_RUNTIME_LEN_EN
  logic [WIDTH-1:0] len_q;
`endif

  assign count_d = count_q + WIDTH'(1);

  opcnt_term_cmp #(
    .WIDTH (WIDTH),
    .LEN   (LEN)
  ) u_term_cmp (
    .count_i (count_q),
`ifdef OPCNT_RUNTIME_LEN_EN
    .len_i   (len_q),
`endif
    .term_o  (term_s)
  );

  // Sequencer FSM with registered busy/ready/count (abort beats terminal count)
  always_ff @(posedge clock or posedge clr) begin
    if (clr) begin
      state_q <= IDLE;
      busy_q  <= 1'b0;
      ready_q <= 1'b0;
      count_q <= '0;
`ifdef OPCNT_RUNTIME_LEN_EN
      len_q   <= WIDTH'(LEN);
`endif
    end else begin
      ready_q <= 1'b0;
      case (state_q)
        IDLE: begin
          count_q <= '0;
          if (bus.start && !bus.abort) begin
            state_q <= RUN;
            busy_q  <= 1'b1;
`ifdef OPCNT_RUNTIME_LEN_EN
            len_q   <= bus.len_in;
`endif
          end else begin
            busy_q  <= 1'b0;
          end
        end
        RUN: begin
          if (bus.abort) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            count_q <= '0;
          end else if (term_s) begin
            count_q <= '0;
            if (READY_DELAY == 32'd0) begin
              state_q <= IDLE;
              busy_q  <= 1'b0;
              ready_q <= 1'b1;
            end else begin
              state_q <= FLUSH;
            end
          end else begin
            count_q <= count_d;
          end
        end
        FLUSH: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          count_q <= '0;
          if (bus.abort) begin
            ready_q <= 1'b0;
          end else begin
            ready_q <= 1'b1;
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          count_q <= '0;
        end
      endcase
    end
  end

  assign bus.busy  = busy_q;
  assign bus.ready = ready_q;
  assign bus.count = count_q;

endmodule

// File: tb/tb_op_cycle_counter.sv
// tb_op_cycle_counter: scoreboard bench. Each accepted start that should
// complete pushes its expected ready cycle; monitors pop on every ready pulse.
// dut_a: LEN=32, READY_DELAY=1. dut_b: LEN=1, READY_DELAY=0.
module tb_op_cycle_counter;

  localparam int W = 6;

  logic clock;
  logic clr;
  int   cyc   = 0;
  int   n_cmp = 0;
  int   n_err = 0;
  int   qa[$];
  int   qb[$];

  op_cycle_counter_if #(.WIDTH(W)) ifa ();
  op_cycle_counter_if #(.WIDTH(W)) ifb ();

  op_cycle_counter #(.WIDTH(W), .LEN(32), .READY_DELAY(1)) dut_a (
    .clock (clock),
    .clr   (clr),
    .bus   (ifa)
  );

  op_cycle_counter #(.WIDTH(W), .LEN(1), .READY_DELAY(0)) dut_b (
    .clock (clock),
    .clr   (clr),
    .bus   (ifb)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  always @(posedge clock) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Ready monitors: every pulse must match the oldest expected completion
  always @(negedge clock) begin
    if (ifa.ready === 1'b1) begin
      if (qa.size() == 0) check_eq("a_ready_spurious", 32'(ifa.ready), 32'd0);
      else                check_eq("a_ready_cycle", cyc, qa.pop_front());
    end
    if (ifb.ready === 1'b1) begin
      if (qb.size() == 0) check_eq("b_ready_spurious", 32'(ifb.ready), 32'd0);
      else                check_eq("b_ready_cycle", cyc, qb.pop_front());
    end
  end

  task automatic tick();
    @(negedge clock);
    #1;
  endtask

  // Start dut_a; when push is set, expect ready L+1 edges after acceptance
  task automatic start_a(input bit push, input int l_cyc);
    ifa.start = 1'b1;
    if (push) qa.push_back(cyc + 1 + l_cyc + 1);
    tick();
    ifa.start = 1'b0;
  endtask

  task automatic start_b();
    ifb.start = 1'b1;
    qb.push_back(cyc + 1 + 1);
    tick();
    ifb.start = 1'b0;
  endtask

  task automatic drain_a(input string tag);
    for (int i = 0; i < 150; i++) begin
      if (!ifa.busy && qa.size() == 0) break;
      tick();
    end
    check_eq({tag, "_pending"}, qa.size(), 32'd0);
    check_eq({tag, "_busy"}, 32'(ifa.busy), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    clr = 1'b0;
    ifa.start = 1'b0; ifa.abort = 1'b0;
    ifb.start = 1'b0; ifb.abort = 1'b0;
`ifdef OPCNT_RUNTIME_LEN_EN
    ifa.len_in = 6'd32;
    ifb.len_in = 6'd1;
`endif
    #2 clr = 1'b1;
    #1;
    check_eq("rst_a_busy",  32'(ifa.busy),  32'd0);
    check_eq("rst_a_ready", 32'(ifa.ready), 32'd0);
    check_eq("rst_a_count", 32'(ifa.count), 32'd0);
    check_eq("rst_b_busy",  32'(ifb.busy),  32'd0);
    tick();
    clr = 1'b0;
    tick();

    // Full LEN=32 operation with one flush cycle
    start_a(1'b1, 32);
    for (int i = 0; i < 32; i++) begin
      check_eq("a_run_count", 32'(ifa.count), 32'(i));
      check_eq("a_run_busy",  32'(ifa.busy),  32'd1);
      tick();
    end
    check_eq("a_flush_busy",  32'(ifa.busy),  32'd1);
    check_eq("a_flush_count", 32'(ifa.count), 32'd0);
    check_eq("a_flush_ready", 32'(ifa.ready), 32'd0);
    tick();
    check_eq("a_done_busy",  32'(ifa.busy),  32'd0);
    check_eq("a_done_ready", 32'(ifa.ready), 32'd1);

    // Back-to-back start in the ready cycle, extra starts while busy ignored
    start_a(1'b1, 32);
    check_eq("a_b2b_busy", 32'(ifa.busy), 32'd1);
    repeat (4) tick();
    ifa.start = 1'b1; tick(); ifa.start = 1'b0;
    repeat (10) tick();
    ifa.start = 1'b1; tick(); ifa.start = 1'b0;
    check_eq("a_ign_count", 32'(ifa.count), 32'd16);
    drain_a("a_b2b");
    tick();
    check_eq("a_ready_one_cycle", 32'(ifa.ready), 32'd0);

    // Abort at count 10
    start_a(1'b0, 32);
    repeat (10) tick();
    check_eq("a_abort10_pre", 32'(ifa.count), 32'd10);
    ifa.abort = 1'b1; tick(); ifa.abort = 1'b0;
    check_eq("a_abort10_busy",  32'(ifa.busy),  32'd0);
    check_eq("a_abort10_count", 32'(ifa.count), 32'd0);
    repeat (40) tick();

    // start and abort together in IDLE
    ifa.start = 1'b1; ifa.abort = 1'b1; tick();
    ifa.start = 1'b0; ifa.abort = 1'b0;
    check_eq("a_sa_idle_busy", 32'(ifa.busy), 32'd0);
    tick();
    check_eq("a_sa_idle_busy2", 32'(ifa.busy), 32'd0);

    // Abort on the terminal-count edge
    start_a(1'b0, 32);
    repeat (31) tick();
    check_eq("a_abort_term_pre", 32'(ifa.count), 32'd31);
    ifa.abort = 1'b1; tick(); ifa.abort = 1'b0;
    check_eq("a_abort_term_busy", 32'(ifa.busy), 32'd0);
    repeat (5) tick();

    // Abort during FLUSH
    start_a(1'b0, 32);
    repeat (32) tick();
    check_eq("a_abort_flush_busy", 32'(ifa.busy), 32'd1);
    ifa.abort = 1'b1; tick(); ifa.abort = 1'b0;
    check_eq("a_abort_flush_busy2", 32'(ifa.busy), 32'd0);
    repeat (5) tick();

    // Asynchronous clr mid-run, then a fresh full-latency operation
    start_a(1'b0, 32);
    repeat (20) tick();
    check_eq("a_clr_pre", 32'(ifa.count), 32'd20);
    #2 clr = 1'b1;
    #1;
    check_eq("a_clr_busy",  32'(ifa.busy),  32'd0);
    check_eq("a_clr_count", 32'(ifa.count), 32'd0);
    check_eq("a_clr_ready", 32'(ifa.ready), 32'd0);
    tick();
    clr = 1'b0;
    tick();
    start_a(1'b1, 32);
    drain_a("a_after_clr");

    // dut_b: LEN=1, READY_DELAY=0, back-to-back
    start_b();
    check_eq("b_run_busy",  32'(ifb.busy),  32'd1);
    check_eq("b_run_count", 32'(ifb.count), 32'd0);
    tick();
    check_eq("b_done_busy",  32'(ifb.busy),  32'd0);
    check_eq("b_done_ready", 32'(ifb.ready), 32'd1);
    start_b();
    check_eq("b_b2b_busy", 32'(ifb.busy), 32'd1);
    tick();
    check_eq("b_b2b_ready", 32'(ifb.ready), 32'd1);
    tick();
    check_eq("b_pending", qb.size(), 32'd0);
    check_eq("b_idle_ready", 32'(ifb.ready), 32'd0);

`ifdef OPCNT_RUNTIME_LEN_EN
    // Runtime length: 5 (changed mid-run to 60), then 0 meaning 64
    ifa.len_in = 6'd5;
    start_a(1'b1, 5);
    ifa.len_in = 6'd60;
    drain_a("a_len5");
    ifa.len_in = 6'd0;
    start_a(1'b1, 64);
    drain_a("a_len0");
    ifa.len_in = 6'd32;
`endif

    repeat (3) tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/op_cycle_counter.md
Name: op_cycle_counter

Overview:
- Parametrised cycle sequencer for multicycle arithmetic units (divider, Booth multiplier).
- On a start request it counts a configurable number of cycles, then pulses `ready` to release the datapath result.
- Generalises the fixed 64-count divider counter with:
  - configurable width and length,
  - an explicit start handshake, busy flag and abort,
  - optional ready delay,
  - optional runtime length.

Parameters:
- WIDTH, 6: count register width in bits.
- LEN, 32: cycles per operation. Legal range 1..2^WIDTH.
- READY_DELAY, 1: extra registered cycles between terminal count and `ready`. Legal values 0 or 1.

Ports:
- clock  in  1  : system clock, rising edge.
- clr  in  1  : asynchronous active-high reset.
- start  in  1  : operation request, sampled on the rising edge.
- abort  in  1  : cancel the current operation, sampled on the rising edge.
- len_in  in  WIDTH  : runtime length. Present only with OPCNT_RUNTIME_LEN_EN. Value 0 means 2^WIDTH.
- busy  out  1  : operation in progress.
- ready  out  1  : single-cycle completion pulse.
- count  out  WIDTH  : cycles elapsed in the current operation.

Behaviour:
- Reset: clr=1 forces, asynchronously, state=IDLE, busy=0, ready=0, count=0, latched length=LEN. Reset mid-operation discards the operation; no ready is produced.
- States:
  - IDLE: busy=0. If start=1 and abort=0 at an edge: count<=0, go to RUN.
  - RUN: busy=1, count increments each edge.
    - At the edge where count==L-1 (L = active length): if READY_DELAY=0, go to IDLE and set ready=1; else go to FLUSH.
    - count wraps to 0 on that edge.
  - FLUSH: busy=1 for exactly one cycle. Next edge: go to IDLE, ready=1.
- Latency: start sampled at edge E0; ready is high in the cycle following edge E(L+READY_DELAY). busy deasserts at that same edge.
- L=1: RUN lasts one cycle. ready follows at edge E1 (READY_DELAY=0) or E2 (READY_DELAY=1).
- ready: registered, high for exactly one cycle, then low unless a new completion occurs.
- Back-to-back: start asserted in the cycle where ready=1 (state IDLE) is accepted. Zero idle gap between operations.
- start while busy=1: ignored. No restart, no error.
- abort:
  - In RUN or FLUSH: go to IDLE next edge, count<=0, no ready pulse.
  - Has priority over a terminal-count transition on the same edge.
  - start and abort together in IDLE: abort wins, stays IDLE.
- count: 0 in IDLE, otherwise the number of RUN edges elapsed. Never exceeds L-1. Holds 0 in FLUSH.

Optional Feature:
- Macro: OPCNT_RUNTIME_LEN_EN.
- Defined:
  - len_in port exists and is latched into a WIDTH-bit length register on the accepting start edge.
  - L = latched value, with 0 meaning 2^WIDTH.
  - Changes to len_in during an operation have no effect.
- Undefined:
  - No len_in port and no length register.
  - L = LEN constant; the terminal compare is against the constant LEN-1.

Decomposition:
- Package opcnt_pkg:
  - state enum: IDLE, RUN, FLUSH (2-bit encoding);
  - localparam helpers: terminal-count function, legal-range check constants.
- Sub-module opcnt_term_cmp: compares count against the active terminal value and produces the terminal flag. Isolates constant vs runtime-length logic.
- Top level holds the FSM, count register and ready register.

Test Plan:
- WIDTH=6, LEN=32, READY_DELAY=1; start pulse at E0 -> busy=1 from E0 through E32; ready=1 only in the cycle after E33; count sequence 0..31.
- READY_DELAY=0, LEN=1; start at E0 -> ready high after E1; busy high for one cycle only.
- Completion, then start asserted during the ready cycle -> new operation accepted; second ready exactly L+READY_DELAY edges later; start pulses while busy ignored.
- abort at count=10 (LEN=32) -> IDLE next edge, count=0, no ready. start+abort together in IDLE -> remains IDLE.
- clr asserted asynchronously mid-RUN (count=20) -> outputs zero immediately without a clock edge; after release, fresh start gives a full 32+1 latency.
- With OPCNT_RUNTIME_LEN_EN, WIDTH=6:
  - len_in=5 -> ready after E6; len_in changed to 60 mid-operation has no effect;
  - len_in=0 -> 64-cycle operation, ready after E65.
